// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } ctrlState_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Code 11 is folded into a word access.
  function automatic logic [2:0] sizeBytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester and RAM-side signals of the memory controller.
interface mem_ctrl_if #(parameter int ADDR_W = mem_ctrl_pkg::ADDR_W_DEF);

  logic              if_req_in;
  logic [ADDR_W-1:0] if_addr_in;
  logic              if_flush_in;
  logic [31:0]       if_data_out;
  logic              if_done_out;
  logic              if_stall_out;

  logic              mem_req_in;
  logic              mem_we_in;
  logic [1:0]        mem_size_in;
  logic [ADDR_W-1:0] mem_addr_in;
  logic [31:0]       mem_wdata_in;
  logic [31:0]       mem_rdata_out;
  logic              mem_done_out;
  logic              mem_stall_out;

  logic [ADDR_W-1:0] ram_a_out;
  logic [7:0]        ram_dout_out;
  logic              ram_wr_out;
  logic [7:0]        ram_din_in;

  modport slave (
    input  if_req_in, if_addr_in, if_flush_in,
    output if_data_out, if_done_out, if_stall_out,
    input  mem_req_in, mem_we_in, mem_size_in, mem_addr_in, mem_wdata_in,
    output mem_rdata_out, mem_done_out, mem_stall_out,
    output ram_a_out, ram_dout_out, ram_wr_out,
    input  ram_din_in
  );

  modport master (
    output if_req_in, if_addr_in, if_flush_in,
    input  if_data_out, if_done_out, if_stall_out,
    output mem_req_in, mem_we_in, mem_size_in, mem_addr_in, mem_wdata_in,
    input  mem_rdata_out, mem_done_out, mem_stall_out,
    input  ram_a_out, ram_dout_out, ram_wr_out,
    output ram_din_in
  );

endinterface

// File: rtl/byte_assembler.sv
// Collects read bytes into a little-endian word; cleared when a new access is accepted.
module byte_assembler (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear,
  input  logic        capture,
  input  logic [1:0]  pos,
  input  logic [7:0]  byteIn,
  output logic [31:0] wordNext
);

  logic [31:0] word;

  // wordNext includes the byte landing this cycle so the final byte can be used at completion.
  always_comb begin
    wordNext = word;
    if (capture) wordNext[{pos, 3'b000} +: 8] = byteIn;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)    word <= '0;
    else if (clear) word <= '0;
    else            word <= wordNext;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port byte-serial memory controller arbitrating IF fetches and MEM loads/stores.
//   state  | meaning
//   IDLE   | arbitrating (blocked during the done cycle)
//   IF_RD  | fetching 4 bytes for IF, cancellable by flush
//   MEM_RD | loading 1/2/4 bytes for MEM
//   MEM_WR | storing 1/2/4 bytes for MEM
module mem_ctrl import mem_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic       clk_in,
  input logic       rst_in,
  mem_ctrl_if.slave bus
);

  ctrlState_e        state, stateNext;
  logic [2:0]        cnt, cntNext;
  logic [2:0]        nBytes;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata;
  logic              ifDone, memDone, ifDoneNext, memDoneNext;
  logic [31:0]       ifData, memRdata;
  logic              acceptIf, acceptMem, finishRd, capture;
  logic [31:0]       asmNext;
  logic              drive;

  always_comb begin
    stateNext   = state;
    cntNext     = 3'd0;
    ifDoneNext  = 1'b0;
    memDoneNext = 1'b0;
    acceptIf    = 1'b0;
    acceptMem   = 1'b0;
    finishRd    = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (!ifDone && !memDone) begin
          if (bus.mem_req_in) begin
            acceptMem = 1'b1;
            stateNext = bus.mem_we_in ? MEM_WR : MEM_RD;
          end else if (bus.if_req_in && !bus.if_flush_in) begin
            acceptIf  = 1'b1;
            stateNext = IF_RD;
          end
        end
      end
      IF_RD, MEM_RD: begin
        // Read data lags the address by one cycle, so capture starts at cnt 1.
        capture = (cnt != 3'd0);
        if (state == IF_RD && bus.if_flush_in) begin
          stateNext = IDLE;
        end else if (cnt == nBytes) begin
          stateNext = IDLE;
          finishRd  = 1'b1;
          if (state == IF_RD) ifDoneNext  = 1'b1;
          else                memDoneNext = 1'b1;
        end else begin
          cntNext = cnt + 3'd1;
        end
      end
      MEM_WR: begin
        if (cnt == nBytes - 3'd1) begin
          stateNext   = IDLE;
          memDoneNext = 1'b1;
        end else begin
          cntNext = cnt + 3'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      nBytes   <= 3'd0;
      base     <= '0;
      wdata    <= '0;
      ifDone   <= 1'b0;
      memDone  <= 1'b0;
      ifData   <= '0;
      memRdata <= '0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      ifDone  <= ifDoneNext;
      memDone <= memDoneNext;
      if (acceptMem) begin
        base   <= bus.mem_addr_in;
        nBytes <= sizeBytes(bus.mem_size_in);
        wdata  <= bus.mem_wdata_in;
      end else if (acceptIf) begin
        base   <= bus.if_addr_in;
        nBytes <= 3'd4;
        wdata  <= '0;
      end
      if (finishRd && state == IF_RD)  ifData   <= asmNext;
      if (finishRd && state == MEM_RD) memRdata <= asmNext;
    end
  end

  byte_assembler u_asm (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear    (acceptIf | acceptMem),
    .capture  (capture),
    .pos      (cnt[1:0] - 2'd1),
    .byteIn   (bus.ram_din_in),
    .wordNext (asmNext)
  );

  assign drive = (state != IDLE) && (cnt < nBytes);

  assign bus.ram_a_out    = drive ? base + ADDR_W'(cnt) : '0;
  assign bus.ram_wr_out   = drive && (state == MEM_WR);
  assign bus.ram_dout_out = (drive && state == MEM_WR) ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;

  assign bus.if_data_out   = ifData;
  assign bus.if_done_out   = ifDone;
  assign bus.if_stall_out  = bus.if_req_in & ~ifDone;
  assign bus.mem_rdata_out = memRdata;
  assign bus.mem_done_out  = memDone;
  assign bus.mem_stall_out = bus.mem_req_in & ~memDone;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-level timeline model plus directed literal checks.
module tb_mem_ctrl;

  logic clk_in;
  logic rst_in;

  mem_ctrl_if #(.ADDR_W(32)) bus();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] initByte(input logic [31:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  // RAM contents seen by the DUT and the model's own view, both indexed by addr[15:0].
  logic [7:0] tRam [0:65535];
  logic [7:0] mMem [0:65535];

  initial begin
    bus.ram_din_in = 8'h00;
    forever begin
      @(posedge clk_in);
      if (bus.ram_wr_out) tRam[bus.ram_a_out[15:0]] = bus.ram_dout_out;
      bus.ram_din_in <= tRam[bus.ram_a_out[15:0]];
    end
  end

  // ---------------- reference model ----------------
  int          cyc = 0;
  bit          modelOn = 1'b1;
  bit          mAct = 1'b0;
  int          mKind;   // 0 IF read, 1 MEM read, 2 MEM write
  logic [31:0] mBase, mWdata, mData;
  int          mN, mStart, mDoneCyc;
  logic [31:0] eIfData = '0, eMemData = '0;

  function automatic int nOf(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  initial begin
    logic [31:0] eA;
    logic [7:0]  eDout;
    logic        eWr, eIfDn, eMemDn;
    int          k;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (!rst_in) begin
        mAct = 1'b0;
        eIfData = '0;
        eMemData = '0;
      end else if (modelOn) begin
        eA = '0; eDout = '0; eWr = 1'b0; eIfDn = 1'b0; eMemDn = 1'b0;
        if (mAct) begin
          k = cyc - mStart - 1;
          if (k >= 0 && k < mN) begin
            eA = mBase + 32'(k);
            if (mKind == 2) begin
              eWr = 1'b1;
              eDout = 8'(mWdata >> (8 * k));
            end
          end
          if (cyc == mDoneCyc) begin
            if (mKind == 0) begin eIfDn = 1'b1; eIfData = mData; end
            else begin
              eMemDn = 1'b1;
              if (mKind == 1) eMemData = mData;
            end
          end
        end
        chk("ram_a", bus.ram_a_out, eA);
        chk("ram_wr", 32'(bus.ram_wr_out), 32'(eWr));
        chk("ram_dout", 32'(bus.ram_dout_out), 32'(eDout));
        chk("if_done", 32'(bus.if_done_out), 32'(eIfDn));
        chk("mem_done", 32'(bus.mem_done_out), 32'(eMemDn));
        chk("if_data", bus.if_data_out, eIfData);
        chk("mem_rdata", bus.mem_rdata_out, eMemData);
        chk("if_stall", 32'(bus.if_stall_out), 32'(bus.if_req_in & ~eIfDn));
        chk("mem_stall", 32'(bus.mem_stall_out), 32'(bus.mem_req_in & ~eMemDn));
        if (mAct) begin
          if (cyc == mDoneCyc) mAct = 1'b0;
          else if (mKind == 0 && bus.if_flush_in) mAct = 1'b0;
        end else if (bus.mem_req_in || (bus.if_req_in && !bus.if_flush_in)) begin
          mAct = 1'b1;
          mStart = cyc;
          if (bus.mem_req_in) begin
            mKind  = bus.mem_we_in ? 2 : 1;
            mBase  = bus.mem_addr_in;
            mN     = nOf(bus.mem_size_in);
            mWdata = bus.mem_wdata_in;
          end else begin
            mKind = 0;
            mBase = bus.if_addr_in;
            mN    = 4;
          end
          mData = '0;
          for (int b = 0; b < mN; b++) begin
            if (mKind == 2) mMem[16'(mBase + 32'(b))] = 8'(mWdata >> (8 * b));
            else mData = mData | (32'(mMem[16'(mBase + 32'(b))]) << (8 * b));
          end
          mDoneCyc = mStart + mN + ((mKind == 2) ? 1 : 2);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    tRam[a[15:0]] = d;
    mMem[a[15:0]] = d;
  endtask

  task automatic randStep(input bit allowNew);
    logic ifDn, memDn, ifFl;
    @(negedge clk_in);
    ifDn  = bus.if_done_out;
    memDn = bus.mem_done_out;
    @(posedge clk_in);
    #1;
    ifFl = bus.if_flush_in;
    bus.if_flush_in = 1'b0;
    if (bus.if_req_in && (ifDn || ifFl)) bus.if_req_in = 1'b0;
    if (!bus.if_req_in) begin
      if (allowNew && $urandom_range(0, 3) == 0) begin
        bus.if_req_in  = 1'b1;
        bus.if_addr_in = 32'h100 + $urandom_range(0, 63);
      end else if ($urandom_range(0, 31) == 0) begin
        bus.if_flush_in = 1'b1;
      end
    end else if ($urandom_range(0, 11) == 0) begin
      bus.if_flush_in = 1'b1;
    end
    if (bus.mem_req_in && memDn) bus.mem_req_in = 1'b0;
    if (!bus.mem_req_in && allowNew && $urandom_range(0, 2) == 0) begin
      bus.mem_req_in   = 1'b1;
      bus.mem_we_in    = 1'($urandom_range(0, 1));
      bus.mem_size_in  = 2'($urandom_range(0, 3));
      bus.mem_addr_in  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                                     : 32'h100 + $urandom_range(0, 63);
      bus.mem_wdata_in = $urandom;
    end
  endtask

  initial begin
    logic [31:0] wrapA [4];
    logic [7:0]  wrapD [4];
    int          guard;

    rst_in = 1'b0;
    bus.if_req_in = 1'b0; bus.if_addr_in = '0; bus.if_flush_in = 1'b0;
    bus.mem_req_in = 1'b0; bus.mem_we_in = 1'b0; bus.mem_size_in = 2'b00;
    bus.mem_addr_in = '0; bus.mem_wdata_in = '0;
    for (int i = 0; i < 65536; i++) begin
      tRam[i] = initByte(32'(i));
      mMem[i] = initByte(32'(i));
    end
    step(); step();
    chk("rst_ram_a", bus.ram_a_out, 32'h0);
    chk("rst_ram_wr", 32'(bus.ram_wr_out), 32'h0);
    chk("rst_if_done", 32'(bus.if_done_out), 32'h0);
    chk("rst_mem_done", 32'(bus.mem_done_out), 32'h0);
    chk("rst_if_data", bus.if_data_out, 32'h0);
    chk("rst_mem_rdata", bus.mem_rdata_out, 32'h0);
    rst_in = 1'b1;
    step();

    // IF word fetch
    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h10); preload(32'h1003, 8'h00);
    bus.if_req_in = 1'b1; bus.if_addr_in = 32'h1000;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 4) chk("fetch_addr", bus.ram_a_out, 32'h1000 + 32'(c - 1));
      if (c == 5) chk("fetch_idle_addr", bus.ram_a_out, 32'h0);
      chk("fetch_done", 32'(bus.if_done_out), (c == 6) ? 32'h1 : 32'h0);
    end
    chk("fetch_data", bus.if_data_out, 32'h0010_0513);
    step();
    bus.if_req_in = 1'b0;
    step();

    // byte store then half load
    preload(32'h102, 8'h11);
    bus.mem_req_in = 1'b1; bus.mem_we_in = 1'b1; bus.mem_size_in = 2'b00;
    bus.mem_addr_in = 32'h103; bus.mem_wdata_in = 32'h1234_56AB;
    step();
    chk("sb_addr", bus.ram_a_out, 32'h103);
    chk("sb_wr", 32'(bus.ram_wr_out), 32'h1);
    chk("sb_dout", 32'(bus.ram_dout_out), 32'hAB);
    step();
    chk("sb_done", 32'(bus.mem_done_out), 32'h1);
    chk("sb_wr_off", 32'(bus.ram_wr_out), 32'h0);
    step();
    bus.mem_we_in = 1'b0; bus.mem_size_in = 2'b01; bus.mem_addr_in = 32'h102;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("lh_done", 32'(bus.mem_done_out), (c == 4) ? 32'h1 : 32'h0);
    end
    chk("lh_data", bus.mem_rdata_out, 32'h0000_AB11);
    step();
    bus.mem_req_in = 1'b0;
    step();

    // simultaneous IF and MEM word load
    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    bus.if_req_in = 1'b1; bus.if_addr_in = 32'h1000;
    bus.mem_req_in = 1'b1; bus.mem_we_in = 1'b0; bus.mem_size_in = 2'b10; bus.mem_addr_in = 32'h100;
    for (int c = 1; c <= 13; c++) begin
      step();
      chk("sim_if_stall", 32'(bus.if_stall_out), (c == 13) ? 32'h0 : 32'h1);
      if (c == 6) begin
        chk("sim_mem_done", 32'(bus.mem_done_out), 32'h1);
        chk("sim_mem_data", bus.mem_rdata_out, 32'hAB11_5678);
      end
      if (c == 7) begin
        chk("sim_cooldown_addr", bus.ram_a_out, 32'h0);
        bus.mem_req_in = 1'b0;
      end
      if (c == 8) chk("sim_if_addr", bus.ram_a_out, 32'h1000);
    end
    chk("sim_if_done", 32'(bus.if_done_out), 32'h1);
    chk("sim_if_data", bus.if_data_out, 32'h0010_0513);
    step();
    bus.if_req_in = 1'b0;
    step();

    // flush mid-fetch, then a clean fetch
    preload(32'h2000, 8'hEF); preload(32'h2001, 8'hBE);
    preload(32'h2002, 8'hAD); preload(32'h2003, 8'hDE);
    bus.if_req_in = 1'b1; bus.if_addr_in = 32'h3000;
    step();
    chk("fl_addr1", bus.ram_a_out, 32'h3000);
    step();
    chk("fl_addr2", bus.ram_a_out, 32'h3001);
    bus.if_flush_in = 1'b1;
    step();
    chk("fl_idle", bus.ram_a_out, 32'h0);
    bus.if_flush_in = 1'b0; bus.if_addr_in = 32'h2000;
    for (int c = 4; c <= 9; c++) begin
      step();
      if (c == 4) chk("fl_new_addr", bus.ram_a_out, 32'h2000);
      chk("fl_done", 32'(bus.if_done_out), (c == 9) ? 32'h1 : 32'h0);
      if (c < 9) chk("fl_data_held", bus.if_data_out, 32'h0010_0513);
    end
    chk("fl_new_data", bus.if_data_out, 32'hDEAD_BEEF);
    step();
    bus.if_req_in = 1'b0;
    step();

    // wrapping word store
    wrapA = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    wrapD = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.mem_req_in = 1'b1; bus.mem_we_in = 1'b1; bus.mem_size_in = 2'b10;
    bus.mem_addr_in = 32'hFFFF_FFFE; bus.mem_wdata_in = 32'h4433_2211;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c <= 4) begin
        chk("wrap_addr", bus.ram_a_out, wrapA[c-1]);
        chk("wrap_dout", 32'(bus.ram_dout_out), 32'(wrapD[c-1]));
      end
      chk("wrap_done", 32'(bus.mem_done_out), (c == 5) ? 32'h1 : 32'h0);
    end
    step();
    bus.mem_req_in = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) randStep(1'b1);
    guard = 0;
    while ((bus.if_req_in || bus.mem_req_in) && guard < 60) begin
      randStep(1'b0);
      guard++;
    end
    chk("drain_idle", 32'(bus.if_req_in | bus.mem_req_in), 32'h0);
    bus.if_flush_in = 1'b0;
    repeat (8) step();

    // async reset during the third byte of a store
    modelOn = 1'b0;
    bus.mem_req_in = 1'b1; bus.mem_we_in = 1'b1; bus.mem_size_in = 2'b10;
    bus.mem_addr_in = 32'h200; bus.mem_wdata_in = 32'h8877_6655;
    step(); step(); step();
    chk("rs_wr_before", 32'(bus.ram_wr_out), 32'h1);
    chk("rs_addr_before", bus.ram_a_out, 32'h202);
    chk("rs_dout_before", 32'(bus.ram_dout_out), 32'h77);
    #2 rst_in = 1'b0;
    #1;
    chk("rs_wr", 32'(bus.ram_wr_out), 32'h0);
    chk("rs_addr", bus.ram_a_out, 32'h0);
    chk("rs_dout", 32'(bus.ram_dout_out), 32'h0);
    chk("rs_if_data", bus.if_data_out, 32'h0);
    chk("rs_mem_rdata", bus.mem_rdata_out, 32'h0);
    chk("rs_mem_stall", 32'(bus.mem_stall_out), 32'h1);
    bus.mem_req_in = 1'b0;
    #1;
    chk("rs_mem_stall_low", 32'(bus.mem_stall_out), 32'h0);
    step(); step();
    rst_in = 1'b1;
    modelOn = 1'b1;
    step(); step();
    chk("post_rs_addr", bus.ram_a_out, 32'h0);

    bus.if_req_in = 1'b1; bus.if_addr_in = 32'h1000;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("post_rs_done", 32'(bus.if_done_out), (c == 6) ? 32'h1 : 32'h0);
      if (c == 5) chk("post_rs_data_clear", bus.if_data_out, 32'h0);
    end
    chk("post_rs_data", bus.if_data_out, 32'h0010_0513);
    step();
    bus.if_req_in = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller and arbiter for the five-stage RISC-V core. It shares one byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM), serialising each access into byte transfers. It produces the `if_stall_out` / `mem_stall_out` levels consumed by the stall controller. MEM is never aborted; IF fetches are cancellable on flush.

## Interface
- `ADDR_W`, 32, byte-address width of requester and RAM addresses.
- `clk_in`  in  1  core clock; all state changes on the rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `if_req_in`  in  1  IF fetch request; level, held until done or flush.
- `if_addr_in`  in  ADDR_W  fetch address; stable while requested.
- `if_flush_in`  in  1  cancel the pending or in-flight fetch (branch/jump).
- `if_data_out`  out  32  fetched word, little-endian; valid while `if_done_out` is high.
- `if_done_out`  out  1  one-cycle completion pulse.
- `if_stall_out`  out  1  `if_req_in & ~if_done_out`; combinational.
- `mem_req_in`  in  1  load/store request; level, held until done.
- `mem_we_in`  in  1  1 = store, 0 = load.
- `mem_size_in`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `mem_addr_in`  in  ADDR_W  base byte address.
- `mem_wdata_in`  in  32  store data; byte k = bits [8k+7:8k].
- `mem_rdata_out`  out  32  load data, zero-extended (sign extension is done in MEM); valid with done.
- `mem_done_out`  out  1  one-cycle completion pulse.
- `mem_stall_out`  out  1  `mem_req_in & ~mem_done_out`; combinational.
- `ram_a_out`  out  ADDR_W  RAM byte address.
- `ram_dout_out`  out  8  RAM write byte.
- `ram_wr_out`  out  1  RAM write strobe.
- `ram_din_in`  in  8  RAM read byte; returns one cycle after its address is presented.

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR. Byte count n: IF reads use n = 4; MEM uses n = 1, 2 or 4 from the size code.
- IDLE arbitration at the clock edge:
  - `mem_req_in` wins over `if_req_in`.
  - An IF request with `if_flush_in` high is not started.
  - Both requests are ignored in any cycle where `if_done_out` or `mem_done_out` is high (one-cycle cooldown).
- On acceptance, the controller latches the address, size, write flag and write data; the requester's values are not sampled again.
- Reads: address `base+k` (mod 2^ADDR_W) is driven in busy cycle k+1, for k = 0..n-1. Byte k is captured from `ram_din_in` at the end of busy cycle k+2 into bits [8k+7:8k]. Unfilled bytes are 0.
- Writes: busy cycles 1..n drive `ram_a_out = base+k`, `ram_dout_out = byte k`, `ram_wr_out = 1`.
- Completion: the controller returns to IDLE and pulses done for exactly one cycle with the data held. Data outputs hold their last value afterwards.
- Flush during IF_RD: the controller goes to IDLE at the next edge. No `if_done_out` pulse, captured bytes are discarded, and `if_data_out` keeps its previous value.
- `if_flush_in` has no effect on MEM_RD or MEM_WR.
- While not driving an address: `ram_a_out = 0`, `ram_wr_out = 0`, `ram_dout_out = 0`.

## Timing
- Request first seen high in IDLE at cycle c0 (no cooldown):
  - Read of n bytes: done high in cycle c0+n+2 (word fetch: 6 cycles).
  - Write of n bytes: done high in cycle c0+n+1.
- Earliest next acceptance is at the end of the cycle after the done cycle.
- If IF is blocked by MEM, it waits the full MEM latency plus cooldown.
- Reset (async, mid-operation included): state IDLE, counter 0. All outputs go to 0 immediately, including `ram_wr_out` and the done pulses. The stall outputs follow the requests combinationally.
- Simultaneous `if_req_in` and `mem_req_in`: MEM first; IF is accepted at the end of the cycle after MEM done, if still requested.

## Structure
- Shared package `mem_ctrl_pkg` holds:
  - state enum;
  - size codes and a size→byte-count function;
  - `ADDR_W` default.
- One sub-module is natural: `byte_assembler`. It takes the shift position and captured byte, produces the 32-bit word, and is cleared on accept. It is reused by both read paths.

## Test plan
- IF fetch at 0x0000_1000, RAM bytes 0x13,0x05,0x10,0x00 → `ram_a_out` steps 0x1000..0x1003 in c1..c4; `if_done_out` in c6 with `if_data_out` = 0x0010_0513.
- MEM byte store 0xAB at 0x0000_0103, then half load from 0x0000_0102 (RAM[0x102] = 0x11) → one write cycle, done at c2; the load returns 0x0000_AB11 at c4.
- IF and MEM requested in the same cycle (word load) → MEM done at c6; IF accepted at the end of c7; `if_stall_out` stays high throughout until IF done.
- `if_flush_in` pulsed in busy cycle 2 of an IF fetch → back to IDLE next edge, no `if_done_out`; a new fetch to 0x2000 proceeds normally.
- Word store at 0xFFFF_FFFE → addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1 (wrap).
- `rst_in` low during the 3rd write byte → `ram_wr_out` drops asynchronously; after release the controller is IDLE with all outputs 0.
